uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one `tx` UART transmitter between NUM_REQ character sources.
- Accepts one byte per grant and drives the transmitter's send/din handshake.
- Waits for the transmitter's busy to rise, then fall, before granting again.
- Sits between the on-chip producers (debug printer, status reporter, and similar) and the single `tx` instance that drives the board TX pin.

---
 rtl/uart_arb_pkg.sv | 25 ++
 rtl/rr_priority.sv | 17 +
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, tag base and round-robin pick helper for the UART TX arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, TAG} arb_state_t;

    localparam logic [7:0] TAG_BASE = 8'h30;

    // Scans upward from last+1 modulo n; returns last unchanged when nothing is requested.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
        logic [2:0] pick;
        logic [2:0] idx;
        logic found;
        pick = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = 3'((int'(last) + k) % n);
            if (k <= n && !found && req[idx]) begin
                pick = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority.sv
// rr_priority: combinational round-robin picker, shared by the TX arbiter and the RX demux.
module rr_priority
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [ID_WIDTH-1:0] gnt_idx,
    output logic                gnt_valid
);

    assign gnt_idx   = ID_WIDTH'(rr_pick(8'(req), 3'(last_grant), NUM_REQ));
    assign gnt_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART tx among NUM_REQ byte sources.
// Define UART_TX_ARBITER_TAG_EN to prefix every byte with the ASCII grantee tag.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int BUSY_TIMEOUT = 16,
    localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*8-1:0]  req_data,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  tx_send,
    output logic [7:0]            tx_din,
    input  logic                  tx_busy,
    output logic [ID_WIDTH-1:0]   grant_id,
    output logic                  active,
    output logic                  timeout_err
);

    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t          state_q, state_d;
    logic [ID_WIDTH-1:0] last_q, last_d, gid_q, gid_d, gnt_idx;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [7:0]          din_q, din_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                send_q, send_d, err_q, err_d, gnt_valid;
`ifdef UART_TX_ARBITER_TAG_EN
    logic [7:0]          data_q, data_d;
    logic                tag_q, tag_d;
`endif

    rr_priority #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
        .req       (req),
        .last_grant(last_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        ack_d   = '0;
        send_d  = send_q;
        din_d   = din_q;
        err_d   = err_q;
        cnt_d   = '0;
`ifdef UART_TX_ARBITER_TAG_EN
        data_d  = data_q;
        tag_d   = tag_q;
`endif
        case (state_q)
            IDLE: if (gnt_valid && !tx_busy) begin
                state_d = SEND;
                send_d  = 1'b1;
                ack_d   = NUM_REQ'(1) << gnt_idx;
                gid_d   = gnt_idx;
                last_d  = gnt_idx;
`ifdef UART_TX_ARBITER_TAG_EN
                din_d   = TAG_BASE + 8'(gnt_idx);
                data_d  = req_data[gnt_idx*8 +: 8];
                tag_d   = 1'b1;
`else
                din_d   = req_data[gnt_idx*8 +: 8];
`endif
            end
            SEND: if (tx_busy) begin
                send_d  = 1'b0;
                state_d = WAIT_DONE;
            end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                // tx never answered: drop the character (and any pending data byte)
                send_d  = 1'b0;
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
`ifdef UART_TX_ARBITER_TAG_EN
            WAIT_DONE: if (!tx_busy) state_d = tag_q ? TAG : IDLE;
            TAG: begin
                din_d   = data_q;
                send_d  = 1'b1;
                tag_d   = 1'b0;
                state_d = SEND;
            end
`else
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= ID_WIDTH'(NUM_REQ - 1);
            gid_q   <= '0;
            ack_q   <= '0;
            send_q  <= 1'b0;
            din_q   <= 8'h00;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef UART_TX_ARBITER_TAG_EN
            data_q  <= 8'h00;
            tag_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            send_q  <= send_d;
            din_q   <= din_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef UART_TX_ARBITER_TAG_EN
            data_q  <= data_d;
            tag_q   <= tag_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign tx_send     = send_q;
    assign tx_din      = din_q;
    assign grant_id    = gid_q;
    assign active      = state_q != IDLE;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a serial tx model and rx decoder at a short bit period.
module tb_uart_tx_arbiter;

    localparam int BP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        tx_send;
    logic [7:0]  tx_din;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rst_gen = 0;
    logic prev_busy = 1'b0;
    logic dead = 1'b0;
    logic busy_m, tx_out;
    logic [9:0] sh;
    int bc, tc;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_send    (tx_send),
        .tx_din     (tx_din),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge rst) rst_gen++;

    // tx model: busy rises the clock after send, 10 bits of BP clocks each
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_m <= 1'b0;
            tx_out <= 1'b1;
            bc     <= 0;
            tc     <= 0;
        end else if (!busy_m) begin
            if (tx_send && !dead) begin
                sh     <= {1'b1, tx_din, 1'b0};
                busy_m <= 1'b1;
                tx_out <= 1'b0;
                bc     <= 0;
                tc     <= 0;
            end
        end else if (tc == BP - 1) begin
            tc <= 0;
            if (bc == 9) busy_m <= 1'b0;
            else begin
                bc     <= bc + 1;
                tx_out <= sh[bc + 1];
            end
        end else begin
            tc <= tc + 1;
        end
    end
    assign tx_busy = busy_m & !dead;

    initial begin
        logic [7:0] b;
        int g;
        forever begin
            @(negedge tx_out);
            g = rst_gen;
            repeat (BP / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BP) @(posedge clk);
                b[i] = tx_out;
            end
            repeat (BP) @(posedge clk);
            if (tx_out && g == rst_gen) rxq.push_back(b);
        end
    end

    always @(negedge clk) begin
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_char(input int id, input logic [7:0] d);
`ifdef UART_TX_ARBITER_TAG_EN
        expq.push_back(8'(8'h30 + id));
`endif
        expq.push_back(d);
    endtask

    task automatic wait_ack(input string tag, input logic [3:0] exp);
        int n = 0;
        while (ack == 4'd0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(ack), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((active || tx_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic drain_rx(input string tag);
        logic [8:0] got;
        logic [7:0] e;
        int n;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n = 0;
            while (rxq.size() == 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            got = (rxq.size() > 0) ? {1'b0, rxq.pop_front()} : 9'h1FF;
            check(tag, 32'(got), 32'(e));
        end
        check({tag, "_extra"}, 32'(rxq.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] first_din;
`ifdef UART_TX_ARBITER_TAG_EN
        first_din = 8'h30;
`else
        first_din = 8'h11;
`endif
        // reset held 80 ns with every requester asking
        rst = 1'b1;
        req = 4'hF;
        req_data = 32'h44332211;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_send", 32'(tx_send), 32'd0);
            check("rst_active", 32'(active), 32'd0);
        end
        check("rst_din", 32'(tx_din), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_ack", 32'(ack), 32'd1);
        check("first_send", 32'(tx_send), 32'd1);
        check("first_din", 32'(tx_din), 32'(first_din));
        check("first_active", 32'(active), 32'd1);
        req = 4'h0;
        exp_char(0, 8'h11);
        @(negedge clk);
        check("first_ack_pulse", 32'(ack), 32'd0);
        wait_idle("first_idle");
        drain_rx("first_rx");

        // single requester
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        @(negedge clk);
        check("single_ack", 32'(ack), 32'b0100);
        check("single_gid", 32'(grant_id), 32'd2);
        req = 4'h0;
        exp_char(2, 8'hA5);
        @(negedge clk);
        check("single_ack_pulse", 32'(ack), 32'd0);
        wait_idle("single_idle");
        check("single_gid_hold", 32'(grant_id), 32'd2);
        drain_rx("single_rx");

        // round-robin from a fresh reset with all requests held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_data = 32'h13121110;
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack("rr_ack", 4'(1 << (k % 4)));
            if (k > 0) check("rr_gap", 32'((cyc - fall_cyc) >= 2), 32'd1);
            exp_char(k % 4, 8'(8'h10 + k % 4));
            if (k == 4) req = 4'h0;
            @(negedge clk);
        end
        wait_idle("rr_idle");
        drain_rx("rr_rx");

        // busy timeout: tx never answers
        dead = 1'b1;
        req_data[15:8] = 8'h77;
        req = 4'b0010;
        wait_ack("to_ack", 4'b0010);
        req = 4'h0;
        begin
            int n = 0;
            while (tx_send && n < 40) begin
                n++;
                @(negedge clk);
            end
            check("to_send_len", 32'(n), 32'd16);
        end
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(active), 32'd0);
        dead = 1'b0;
        repeat (4) @(negedge clk);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        check("to_no_rx", 32'(rxq.size()), 32'd0);

        // reset in the middle of a character
        req_data[7:0] = 8'h5A;
        req = 4'b0001;
        wait_ack("mid_ack", 4'b0001);
        req = 4'h0;
        repeat (4 * BP) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_send", 32'(tx_send), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_tx_out", 32'(tx_out), 32'd1);
        check("mid_busy", 32'(tx_busy), 32'd0);
        check("mid_send", 32'(tx_send), 32'd0);
        check("mid_active", 32'(active), 32'd0);
        check("mid_err_clr", 32'(timeout_err), 32'd0);
        repeat (12 * BP) @(negedge clk);
        check("mid_no_rx", 32'(rxq.size()), 32'd0);
        req_data[31:24] = 8'h3C;
        req = 4'b1000;
        wait_ack("mid_new_ack", 4'b1000);
        check("mid_new_gid", 32'(grant_id), 32'd3);
        req = 4'h0;
        exp_char(3, 8'h3C);
        @(negedge clk);
        check("mid_new_pulse", 32'(ack), 32'd0);
        wait_idle("mid_new_idle");
        drain_rx("mid_new_rx");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
